// File: rtl/pfd_loop_pkg.sv
// Shared types, default constants and arithmetic helpers for the PFD digital loop filter.
package pfd_loop_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    UPDATE  = 2'd2
  } state_t;

  localparam int DEF_CNT_W        = 8;
  localparam int DEF_WINDOW       = 64;
  localparam int DEF_INT_W        = 16;
  localparam int DEF_CTRL_W       = 6;
  localparam int DEF_CTRL_INIT    = 32;
  localparam int DEF_KP_SHIFT     = 2;
  localparam int DEF_KI_SHIFT     = 4;
  localparam int DEF_LOCK_TOL     = 2;
  localparam int DEF_LOCK_WINDOWS = 4;

  // Saturate to the two's-complement range of a width-bit signed value (width <= 31).
  function automatic int sat_signed(input int value, input int width);
    int hi;
    int lo;
    hi = (1 << (width - 1)) - 1;
    lo = -(1 << (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

  function automatic int clamp_unsigned(input int value, input int width);
    int hi;
    hi = (1 << width) - 1;
    if (value < 0) return 0;
    if (value > hi) return hi;
    return value;
  endfunction

endpackage

// File: rtl/pfd_pulse_sync.sv
// Two-flop synchronizer bringing an asynchronous PFD pulse into the sampling clock domain.
module pfd_pulse_sync (
  input  logic clk,
  input  logic delay_up_reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample pre-edge values.
  always_ff @(posedge clk or negedge delay_up_reset) begin
    if (!delay_up_reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pfd_digital_loop_filter.sv
// Windowed up/down pulse-width measurement followed by a PI update of the ring-oscillator
// control code, with per-window phase error and lock detection.
module pfd_digital_loop_filter
  import pfd_loop_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int WINDOW       = DEF_WINDOW,
  parameter int INT_W        = DEF_INT_W,
  parameter int CTRL_W       = DEF_CTRL_W,
  parameter int CTRL_INIT    = DEF_CTRL_INIT,
  parameter int KP_SHIFT     = DEF_KP_SHIFT,
  parameter int KI_SHIFT     = DEF_KI_SHIFT,
  parameter int LOCK_TOL     = DEF_LOCK_TOL,
  parameter int LOCK_WINDOWS = DEF_LOCK_WINDOWS
) (
  input  logic                    clk,
  input  logic                    delay_up_reset,
  input  logic                    enable,
  input  logic                    up,
  input  logic                    down,
  output logic [CTRL_W-1:0]       ctrl,
  output logic                    ctrl_valid,
  output logic signed [CNT_W:0]   err_out,
  output logic                    locked,
  output logic                    sat_flag
);

  localparam int ERR_W      = CNT_W + 1;
  localparam int LOCK_CNT_W = $clog2(LOCK_WINDOWS + 1);
  localparam logic [CNT_W-1:0]      WIN_LAST  = CNT_W'(WINDOW - 1);
  localparam logic [LOCK_CNT_W-1:0] LOCK_MAX  = LOCK_CNT_W'(LOCK_WINDOWS);
  localparam logic [LOCK_CNT_W-1:0] LOCK_LAST = LOCK_CNT_W'(LOCK_WINDOWS - 1);

  logic up_s;
  logic down_s;

  pfd_pulse_sync u_sync_up (
    .clk            (clk),
    .delay_up_reset (delay_up_reset),
    .d              (up),
    .q              (up_s)
  );

  pfd_pulse_sync u_sync_down (
    .clk            (clk),
    .delay_up_reset (delay_up_reset),
    .d              (down),
    .q              (down_s)
  );

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0]          win_cnt;
  logic [CNT_W-1:0]          up_cnt;
  logic [CNT_W-1:0]          down_cnt;
  logic signed [INT_W-1:0]   integ;
  logic [LOCK_CNT_W-1:0]     lock_cnt;

  int   err_i;
  int   integ_raw;
  int   integ_i;
  int   sum_raw;
  int   sum_i;
  logic sat_c;
  logic in_tol;

  // PI arithmetic is done in 32-bit ints so the saturation/clamp checks see the true values.
  // NOTE: every combinational output is given a default first so no latch is inferred.
  always_comb begin
    err_i     = int'(up_cnt) - int'(down_cnt);
    integ_raw = int'(integ) + err_i;
    integ_i   = sat_signed(integ_raw, INT_W);
    sum_raw   = CTRL_INIT + (integ_i >>> KI_SHIFT) + (err_i >>> KP_SHIFT);
    sum_i     = clamp_unsigned(sum_raw, CTRL_W);
    sat_c     = (integ_i != integ_raw) || (sum_i != sum_raw);
    in_tol    = (err_i <= LOCK_TOL) && (err_i >= -LOCK_TOL);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = MEASURE;
      MEASURE: begin
        if (!enable)                  state_nxt = IDLE;
        else if (win_cnt == WIN_LAST) state_nxt = UPDATE;
      end
      UPDATE:  state_nxt = enable ? MEASURE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge delay_up_reset) begin
    if (!delay_up_reset) state <= IDLE;
    else                 state <= state_nxt;
  end

  // Counters only run while measuring with enable high; any other cycle discards the window.
  always_ff @(posedge clk or negedge delay_up_reset) begin
    if (!delay_up_reset) begin
      win_cnt  <= '0;
      up_cnt   <= '0;
      down_cnt <= '0;
    end else if (state == MEASURE && enable) begin
      win_cnt  <= win_cnt + 1'b1;
      up_cnt   <= up_cnt + {{(CNT_W-1){1'b0}}, up_s};
      down_cnt <= down_cnt + {{(CNT_W-1){1'b0}}, down_s};
    end else begin
      win_cnt  <= '0;
      up_cnt   <= '0;
      down_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge delay_up_reset) begin
    if (!delay_up_reset) begin
      ctrl       <= CTRL_W'(CTRL_INIT);
      ctrl_valid <= 1'b0;
      err_out    <= '0;
      locked     <= 1'b0;
      sat_flag   <= 1'b0;
      integ      <= '0;
      lock_cnt   <= '0;
    end else begin
      ctrl_valid <= 1'b0;
      case (state)
        IDLE: begin
          locked   <= 1'b0;
          lock_cnt <= '0;
        end
        UPDATE: begin
          ctrl       <= CTRL_W'(sum_i);
          err_out    <= ERR_W'(err_i);
          integ      <= INT_W'(integ_i);
          sat_flag   <= sat_c;
          ctrl_valid <= 1'b1;
          // Lock counter saturates at LOCK_WINDOWS; one out-of-tolerance window drops lock.
          if (in_tol) begin
            if (lock_cnt != LOCK_MAX) lock_cnt <= lock_cnt + 1'b1;
            locked <= (lock_cnt >= LOCK_LAST);
          end else begin
            lock_cnt <= '0;
            locked   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pfd_digital_loop_filter.sv
// Self-checking bench: directed scenarios plus random pulse densities, compared against a
// window-level arithmetic model of the loop filter.
module tb_pfd_digital_loop_filter;

  localparam int CNT_W        = 8;
  localparam int WINDOW       = 64;
  localparam int INT_W        = 16;
  localparam int CTRL_W       = 6;
  localparam int CTRL_INIT    = 32;
  localparam int KP_SHIFT     = 2;
  localparam int KI_SHIFT     = 4;
  localparam int LOCK_TOL     = 2;
  localparam int LOCK_WINDOWS = 4;
  localparam int MAX_CYC      = 16384;

  localparam int M_HOLD  = 0;
  localparam int M_RAND  = 1;
  localparam int M_PULSE = 2;

  logic                  clk            = 1'b0;
  logic                  delay_up_reset = 1'b1;
  logic                  enable         = 1'b0;
  logic                  up             = 1'b0;
  logic                  down           = 1'b0;
  logic [CTRL_W-1:0]     ctrl;
  logic                  ctrl_valid;
  logic signed [CNT_W:0] err_out;
  logic                  locked;
  logic                  sat_flag;

  pfd_digital_loop_filter #(
    .CNT_W        (CNT_W),
    .WINDOW       (WINDOW),
    .INT_W        (INT_W),
    .CTRL_W       (CTRL_W),
    .CTRL_INIT    (CTRL_INIT),
    .KP_SHIFT     (KP_SHIFT),
    .KI_SHIFT     (KI_SHIFT),
    .LOCK_TOL     (LOCK_TOL),
    .LOCK_WINDOWS (LOCK_WINDOWS)
  ) dut (
    .clk            (clk),
    .delay_up_reset (delay_up_reset),
    .enable         (enable),
    .up             (up),
    .down           (down),
    .ctrl           (ctrl),
    .ctrl_valid     (ctrl_valid),
    .err_out        (err_out),
    .locked         (locked),
    .sat_flag       (sat_flag)
  );

  always #5 clk = ~clk;

  // Input levels seen at each rising edge; the DUT counts the level from two edges earlier.
  int   cyc = 0;
  logic up_hist   [MAX_CYC];
  logic down_hist [MAX_CYC];

  always @(posedge clk) begin
    if (cyc < MAX_CYC) begin
      up_hist[cyc]   = up;
      down_hist[cyc] = down;
    end
    cyc++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  int m_integ;
  int m_ctrl;
  int m_err;
  int m_lock_cnt;
  int m_locked;
  int m_sat;
  int next_s;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_integ    = 0;
    m_ctrl     = CTRL_INIT;
    m_err      = 0;
    m_lock_cnt = 0;
    m_locked   = 0;
    m_sat      = 0;
  endtask

  // One PI update from the first sampling edge s of a window.
  task automatic model_window(input int s);
    int uc;
    int dc;
    int raw;
    int sum;
    uc = 0;
    dc = 0;
    for (int t = s; t < s + WINDOW; t++) begin
      if (up_hist[t-2] === 1'b1)   uc++;
      if (down_hist[t-2] === 1'b1) dc++;
    end
    m_err = uc - dc;
    m_sat = 0;
    raw   = m_integ + m_err;
    if (raw > (1 << (INT_W - 1)) - 1) begin raw = (1 << (INT_W - 1)) - 1; m_sat = 1; end
    if (raw < -(1 << (INT_W - 1)))    begin raw = -(1 << (INT_W - 1));    m_sat = 1; end
    m_integ = raw;
    sum = CTRL_INIT + (m_integ >>> KI_SHIFT) + (m_err >>> KP_SHIFT);
    if (sum < 0)                 begin sum = 0;                 m_sat = 1; end
    if (sum > (1 << CTRL_W) - 1) begin sum = (1 << CTRL_W) - 1; m_sat = 1; end
    m_ctrl = sum;
    if (m_err <= LOCK_TOL && m_err >= -LOCK_TOL) begin
      if (m_lock_cnt < LOCK_WINDOWS) m_lock_cnt++;
    end else begin
      m_lock_cnt = 0;
    end
    m_locked = (m_lock_cnt == LOCK_WINDOWS) ? 1 : 0;
  endtask

  task automatic drive(input int mode, input int i, input int pa, input int pb);
    case (mode)
      M_RAND: begin
        up   = (int'($urandom_range(99)) < pa);
        down = (int'($urandom_range(99)) < pb);
      end
      M_PULSE: begin
        up   = (i >= 5) && (i < 5 + pa);
        down = (i >= 5) && (i < 5 + pb);
      end
      default: ;
    endcase
  endtask

  task automatic do_reset(input logic u, input logic d);
    @(negedge clk);
    delay_up_reset = 1'b0;
    enable = 1'b0;
    up     = u;
    down   = d;
    repeat (3) @(negedge clk);
    check("rst_ctrl", ctrl, CTRL_INIT);
    check("rst_locked", locked, 0);
    check("rst_valid", ctrl_valid, 0);
    check("rst_err", $signed(err_out), 0);
    check("rst_sat", sat_flag, 0);
    delay_up_reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
  endtask

  task automatic start_enable();
    @(negedge clk);
    enable = 1'b1;
    next_s = cyc + 1;
  endtask

  // Runs until the next ctrl_valid (bounded) and checks the update against the model.
  task automatic run_window(input string tag, input int mode, input int pa, input int pb);
    bit seen;
    int i;
    seen = 1'b0;
    i    = 0;
    while (!seen && i < WINDOW + 8) begin
      drive(mode, i, pa, pb);
      @(negedge clk);
      if (ctrl_valid === 1'b1) seen = 1'b1;
      i++;
    end
    check({tag, "_valid"}, ctrl_valid, 1);
    check({tag, "_latency"}, cyc, next_s + WINDOW + 1);
    model_window(next_s);
    check({tag, "_ctrl"}, ctrl, m_ctrl);
    check({tag, "_err"}, $signed(err_out), m_err);
    check({tag, "_locked"}, locked, m_locked);
    check({tag, "_sat"}, sat_flag, m_sat);
    next_s += WINDOW + 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int nvalid;
    int pa;
    int pb;
    model_reset();

    // Constant lead: integrator ramps until the clamp engages.
    do_reset(1'b1, 1'b0);
    start_enable();
    run_window("lead1", M_HOLD, 0, 0);
    check("lead1_ctrl_abs", ctrl, 52);
    check("lead1_err_abs", $signed(err_out), 64);
    run_window("lead2", M_HOLD, 0, 0);
    check("lead2_ctrl_abs", ctrl, 56);
    run_window("lead3", M_HOLD, 0, 0);
    run_window("lead4", M_HOLD, 0, 0);
    check("lead4_ctrl_abs", ctrl, 63);
    check("lead4_sat_abs", sat_flag, 1);
    run_window("lead5", M_HOLD, 0, 0);
    run_window("lead6", M_HOLD, 0, 0);
    check("lead6_ctrl_abs", ctrl, 63);

    // Asynchronous clear between clock edges.
    repeat (20) @(negedge clk);
    #2;
    delay_up_reset = 1'b0;
    #1;
    check("async_ctrl", ctrl, CTRL_INIT);
    check("async_valid", ctrl_valid, 0);
    check("async_err", $signed(err_out), 0);
    check("async_locked", locked, 0);
    check("async_sat", sat_flag, 0);
    model_reset();

    // Balanced inputs: lock after four in-tolerance windows, then lost on an error burst.
    do_reset(1'b0, 1'b0);
    start_enable();
    for (int w = 1; w <= 4; w++) run_window("bal", M_HOLD, 0, 0);
    check("bal_locked_abs", locked, 1);
    check("bal_ctrl_abs", ctrl, 32);
    run_window("burst", M_PULSE, 10, 0);
    check("burst_err_abs", $signed(err_out), 10);
    check("burst_locked_abs", locked, 0);

    // Mixed pulse widths.
    do_reset(1'b0, 1'b0);
    start_enable();
    run_window("mix1", M_PULSE, 20, 8);
    check("mix1_err_abs", $signed(err_out), 12);
    check("mix1_ctrl_abs", ctrl, 35);
    run_window("mix2", M_PULSE, 20, 8);
    check("mix2_ctrl_abs", ctrl, 36);

    // Enable dropped mid-window: partial counts discarded, no update.
    for (int i = 0; i < 30; i++) begin
      drive(M_RAND, i, 60, 20);
      @(negedge clk);
    end
    enable = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 2 * WINDOW; i++) begin
      drive(M_RAND, i, 60, 20);
      @(negedge clk);
      if (ctrl_valid !== 1'b0) nvalid++;
    end
    check("drop_no_valid", nvalid, 0);
    check("drop_ctrl", ctrl, m_ctrl);
    check("drop_locked", locked, 0);
    m_lock_cnt = 0;
    m_locked   = 0;
    start_enable();
    run_window("reen", M_RAND, 50, 30);

    // Random pulse densities, occasionally balanced.
    for (int w = 0; w < 10; w++) begin
      pa = int'($urandom_range(100));
      pb = (w % 3 == 0) ? pa : int'($urandom_range(100));
      run_window("rand", M_RAND, pa, pb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pfd_digital_loop_filter.md
Name: pfd_digital_loop_filter

Overview:
- Consumes the asynchronous up/down pulse pair from the phase-frequency detector stage.
- Measures pulse widths over a fixed sampling window on a fast sampling clock, then runs a proportional-integral update.
- Emits a clamped control code that selects the ring-oscillator delay setting.
- Also reports the per-window phase error and a lock indication.

Parameters:
- CNT_W, 8, width of up/down width counters; WINDOW must be <= 2^CNT_W-1.
- WINDOW, 64, sampling clocks per measurement window.
- INT_W, 16, signed integrator width.
- CTRL_W, 6, control code width.
- CTRL_INIT, 32, control code at reset and the offset added to the PI sum.
- KP_SHIFT, 2, proportional term = err >>> KP_SHIFT.
- KI_SHIFT, 4, integral term = integ >>> KI_SHIFT.
- LOCK_TOL, 2, |err| <= LOCK_TOL counts as an in-tolerance window.
- LOCK_WINDOWS, 4, consecutive in-tolerance windows required for lock.

Ports:
- clk  in  1  sampling clock; all state is on the rising edge.
- delay_up_reset  in  1  reset delay_up_reset, asynchronous, active-low.
- enable  in  1  run loop; low forces IDLE.
- up  in  1  asynchronous PFD up pulse (ref leads feedback).
- down  in  1  asynchronous PFD down pulse (feedback leads ref).
- ctrl  out  CTRL_W  oscillator control code.
- ctrl_valid  out  1  one-cycle strobe when ctrl/err_out are updated.
- err_out  out  CNT_W+1  signed error of the last window.
- locked  out  1  lock indication.
- sat_flag  out  1  last update was clamped or integrator saturated.

Behaviour:
- Reset values (delay_up_reset low, asynchronous):
  - ctrl=CTRL_INIT, err_out=0, ctrl_valid=0, locked=0, sat_flag=0.
  - integ=0, counters=0, state=IDLE, synchronizer flops=0.
- Synchronization: up and down each pass a 2-flop synchronizer, giving 2-cycle latency. Only the synchronized versions up_s and down_s are used.
- IDLE:
  - Counters held at 0; ctrl and integ hold their values; locked=0.
  - enable=1 -> MEASURE on the next edge.
- MEASURE:
  - Window counter runs 0..WINDOW-1.
  - up_cnt increments each cycle up_s=1; down_cnt increments each cycle down_s=1. Both may increment in the same cycle.
  - On the cycle with window count WINDOW-1 (sample included) -> UPDATE.
- UPDATE (exactly 1 cycle):
  - err = up_cnt - down_cnt, signed CNT_W+1.
  - integ_n = integ + err, saturated to the signed INT_W range.
  - sum = CTRL_INIT + (integ_n >>> KI_SHIFT) + (err >>> KP_SHIFT), clamped to [0, 2^CTRL_W-1].
  - On the exit edge: ctrl=sum, err_out=err, integ=integ_n, and counters clear.
  - sat_flag=1 if the clamp or integrator saturation occurred, else 0.
  - ctrl_valid=1 for the following cycle only.
  - Next state: MEASURE if enable=1, else IDLE.
- Latency: ctrl_valid rises 2 edges after the last sampled window cycle.
- Windows are back-to-back: period WINDOW+1 clocks.
- Lock:
  - Consecutive-window counter increments on each UPDATE with |err| <= LOCK_TOL.
  - It resets to 0 otherwise, and also clears locked.
  - locked=1 once the counter reaches LOCK_WINDOWS; the counter saturates there.
  - locked updates together with ctrl.
- enable falling mid-window:
  - Return to IDLE on the next edge and discard the partial counts.
  - No ctrl_valid; ctrl and integ retained.
- Reset asserted mid-operation: all state returns to reset values immediately. Operation resumes from IDLE after the first clk edge with reset high.
- Sign convention: positive err (up dominant) increases ctrl.

Decomposition:
- Shared package pfd_loop_pkg holds:
  - state enum {IDLE, MEASURE, UPDATE};
  - default parameter constants;
  - functions sat_signed(value, width) and clamp_unsigned(value, width).
- Sub-module pfd_pulse_sync: 2-flop synchronizer, reset by delay_up_reset. Instantiated twice, once for up and once for down.

Test Plan:
- Reset sequence: with delay_up_reset low for 3 clocks, check ctrl=32, locked=0, ctrl_valid=0. Assert the async clear between clock edges and confirm the outputs change without a clk edge.
- Constant lead: up=1, down=0 held before enable. Window 1: err_out=+64, ctrl=52 (32+4+16). Window 2: ctrl=56, sat_flag=0.
- Saturation: continue constant up. Window 4: integ=256, sum=64 -> ctrl=63, sat_flag=1. ctrl stays 63 on later windows.
- Balance and lock: up=down=0 from reset. Every window: err_out=0, ctrl=32. locked rises with the 4th ctrl_valid. Then inject up=1 for 10 cycles in one window: err_out=+10, locked=0.
- Mixed pulses: up high 20 cycles and down high 8 cycles per window. err_out=+12, ctrl=32+0+3=35 on window 1 (integ=12 -> integral term 0). Window 2: integ=24 -> ctrl=36.
- Enable drop: deassert enable at window count 30. Expect no ctrl_valid and ctrl unchanged. After re-enable, the next ctrl_valid comes WINDOW+1 clocks after entering MEASURE, with counts starting from zero.
